// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: states, opcodes and
// the select/op codes it drives into the datapath.
package rv32_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DEC   = 3'd2;
  localparam logic [2:0] ST_EXE   = 3'd3;
  localparam logic [2:0] ST_MEM   = 3'd4;
  localparam logic [2:0] ST_WB    = 3'd5;
  localparam logic [2:0] ST_TRAP  = 3'd7;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_REL    = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;
  localparam logic       SRC_B_RS2  = 1'b0;
  localparam logic       SRC_B_IMM  = 1'b1;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_re;
    logic       dmem_we;
    logic       ir_write;
    logic       reg_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
    logic       trap;
  } ctrl_t;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal_opcode = 1'b1;
      default:                           is_legal_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts stalled cycles of a memory handshake and flags the cycle on which
// the wait would exceed TIMEOUT_CYC (a ready on that same cycle still wins).
module mc_wait_timer #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST_STALL =
    CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  logic [CNT_W-1:0] cnt;

  // Held at zero outside the wait state, so every entry starts a fresh count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!active) begin
      cnt <= '0;
    end else if (!ready && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (TIMEOUT_CYC != 0) && active && !ready && (cnt == LAST_STALL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch handshake, decode, execute, memory
// and write-back sequencing, with a sticky trap on illegal opcode or timeout.
module multicycle_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] inst,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        ir_write,
  output logic        reg_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [2:0]  state_o
);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [6:0] opcode;
  logic       is_load;
  logic       is_store;
  logic       imem_expired;
  logic       dmem_expired;
  logic       unused_inst;
  ctrl_t      ctrl;

  assign opcode      = inst[6:0];
  assign is_load     = (opcode == OP_LOAD);
  assign is_store    = (opcode == OP_STORE);
  assign unused_inst = ^{inst[31:13], inst[11:7]};

  mc_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) u_imem_timer (
    .clk     (clk),
    .rst     (rst),
    .active  (state_q == ST_FETCH),
    .ready   (imem_ready),
    .expired (imem_expired)
  );

  mc_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) u_dmem_timer (
    .clk     (clk),
    .rst     (rst),
    .active  (state_q == ST_MEM),
    .ready   (dmem_ready),
    .expired (dmem_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // run is only consulted where an instruction ends, so a started one always completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready)        state_d = ST_DEC;
        else if (imem_expired) state_d = ST_TRAP;
      end
      ST_DEC:   state_d = is_legal_opcode(opcode) ? ST_EXE : ST_TRAP;
      ST_EXE: begin
        case (opcode)
          OP_BRANCH:          state_d = run ? ST_FETCH : ST_IDLE;
          OP_LOAD, OP_STORE:  state_d = ST_MEM;
          OP_R, OP_I, OP_JAL, OP_JALR,
          OP_LUI, OP_AUIPC:   state_d = ST_WB;
          default:            state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (dmem_ready)        state_d = is_load ? ST_WB : (run ? ST_FETCH : ST_IDLE);
        else if (dmem_expired) state_d = ST_TRAP;
      end
      ST_WB:    state_d = run ? ST_FETCH : ST_IDLE;
      ST_TRAP:  state_d = ST_TRAP;
      default:  state_d = ST_TRAP;
    endcase
  end

  // The only input-dependent strobes are the IR/PC load on fetch completion and the branch decision.
  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.imem_req = 1'b1;
        if (imem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_PLUS4;
        end
      end
      ST_EXE: begin
        case (opcode)
          OP_R: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_RS2;
            ctrl.alu_op    = ALU_RTYPE;
          end
          OP_I: begin
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_ITYPE;
          end
          OP_LOAD, OP_STORE: begin
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_ADD;
          end
          OP_BRANCH: begin
            ctrl.alu_op   = ALU_BR;
            ctrl.pc_src   = PC_REL;
            ctrl.pc_write = zero ^ inst[12];
          end
          OP_JAL: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PC_REL;
          end
          OP_JALR: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PC_JALR;
          end
          OP_LUI: begin
            ctrl.alu_src_a = SRC_A_ZERO;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_ADD;
          end
          OP_AUIPC: begin
            ctrl.alu_src_a = SRC_A_PC;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_ADD;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        ctrl.dmem_re = is_load;
        ctrl.dmem_we = is_store;
      end
      ST_WB: begin
        ctrl.reg_write = 1'b1;
        if (is_load)                                    ctrl.wb_sel = WB_LOAD;
        else if ((opcode == OP_JAL) || (opcode == OP_JALR)) ctrl.wb_sel = WB_PC4;
        else                                            ctrl.wb_sel = WB_ALU;
      end
      ST_TRAP:  ctrl.trap = 1'b1;
      default: ;
    endcase
  end

  assign imem_req  = ctrl.imem_req;
  assign dmem_re   = ctrl.dmem_re;
  assign dmem_we   = ctrl.dmem_we;
  assign ir_write  = ctrl.ir_write;
  assign reg_write = ctrl.reg_write;
  assign pc_write  = ctrl.pc_write;
  assign pc_src    = ctrl.pc_src;
  assign alu_src_a = ctrl.alu_src_a;
  assign alu_src_b = ctrl.alu_src_b;
  assign alu_op    = ctrl.alu_op;
  assign wb_sel    = ctrl.wb_sel;
  assign trap      = ctrl.trap;
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl (TIMEOUT_CYC=4): one table
// row per clock cycle plus hand sequences for reset, trap and timeout corners.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] state;
    logic       imem_req, dmem_re, dmem_we, ir_write, reg_write, pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
    logic       trap;
  } out_t;

  typedef struct {
    logic        run, imr, dmr, zero;
    logic [31:0] inst;
    out_t        exp;
  } vec_t;

  localparam logic [31:0] I_ADDI = 32'h00000293;
  localparam logic [31:0] I_LW   = 32'hFFC12083;
  localparam logic [31:0] I_BEQ  = 32'h80310063;
  localparam logic [31:0] I_SW   = 32'h00112223;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [31:0] inst = '0;
  logic        zero = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, dmem_re, dmem_we, ir_write, reg_write, pc_write;
  logic [1:0]  pc_src, alu_src_a, alu_op, wb_sel;
  logic        alu_src_b, trap;
  logic [2:0]  state_o;

  int num_checks = 0;
  int num_pass   = 0;
  vec_t vecs[$];

  multicycle_ctrl #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .inst       (inst),
    .zero       (zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .dmem_re    (dmem_re),
    .dmem_we    (dmem_we),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .wb_sel     (wb_sel),
    .trap       (trap),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  // strobes order: imem_req, dmem_re, dmem_we, ir_write, reg_write, pc_write
  function automatic out_t mk(input logic [2:0] st, input logic [5:0] stb,
                              input logic [1:0] pcs, input logic [1:0] sa,
                              input logic sb, input logic [1:0] op,
                              input logic [1:0] wb, input logic tr);
    mk = {st, stb, pcs, sa, sb, op, wb, tr};
  endfunction

  function automatic void addVec(input logic r, input logic im, input logic dm,
                                 input logic z, input logic [31:0] ins, input out_t e);
    vec_t v;
    v.run = r; v.imr = im; v.dmr = dm; v.zero = z; v.inst = ins; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    run        = v.run;
    imem_ready = v.imr;
    dmem_ready = v.dmr;
    zero       = v.zero;
    inst       = v.inst;
    #1;
  endtask

  task automatic checkOutput(input string name, input out_t exp);
    out_t act;
    act = {state_o, imem_req, dmem_re, dmem_we, ir_write, reg_write, pc_write,
           pc_src, alu_src_a, alu_src_b, alu_op, wb_sel, trap};
    num_checks++;
    if (act === exp) num_pass++;
    else $display("[TB] FAIL %s: got %05h expected %05h", name, act, exp);
  endtask

  task automatic stepCheck(input string name, input logic r, input logic im,
                           input logic dm, input logic z, input logic [31:0] ins,
                           input out_t e);
    vec_t v;
    v.run = r; v.imr = im; v.dmr = dm; v.zero = z; v.inst = ins; v.exp = e;
    applyStimulus(v);
    checkOutput(name, e);
  endtask

  // Asserts reset mid-cycle, checks outputs drop at once, releases on the next negedge.
  task automatic resetPulse(input string name);
    #1;
    rst = 1'b0;
    run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
    #1;
    checkOutput(name, mk(3'd0, 6'b0, 2'b0, 2'b0, 1'b0, 2'b0, 2'b0, 1'b0));
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    out_t o_idle, o_fetch, o_fetch_rdy, o_dec, o_trap;
    o_idle      = mk(3'd0, 6'b000000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    o_fetch     = mk(3'd1, 6'b100000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    o_fetch_rdy = mk(3'd1, 6'b100101, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    o_dec       = mk(3'd2, 6'b000000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    o_trap      = mk(3'd7, 6'b000000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1);

    for (int i = 0; i < 5; i++) addVec(0, 0, 0, 0, I_ADDI, o_idle);
    // addi x5,x0,0
    addVec(1, 0, 0, 0, I_ADDI, o_idle);
    addVec(1, 1, 0, 0, I_ADDI, o_fetch_rdy);
    addVec(1, 0, 0, 0, I_ADDI, o_dec);
    addVec(1, 0, 0, 0, I_ADDI, mk(3'd3, 6'b000000, 2'b00, 2'b00, 1'b1, 2'b11, 2'b00, 1'b0));
    addVec(1, 0, 0, 0, I_ADDI, mk(3'd5, 6'b000010, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0));
    // lw x1,-4(x2), data memory ready on third MEM cycle
    addVec(1, 1, 0, 0, I_LW, o_fetch_rdy);
    addVec(1, 0, 0, 0, I_LW, o_dec);
    addVec(1, 0, 0, 0, I_LW, mk(3'd3, 6'b000000, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0));
    addVec(1, 0, 0, 0, I_LW, mk(3'd4, 6'b010000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0));
    addVec(1, 0, 0, 0, I_LW, mk(3'd4, 6'b010000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0));
    addVec(1, 0, 1, 0, I_LW, mk(3'd4, 6'b010000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0));
    addVec(1, 0, 0, 0, I_LW, mk(3'd5, 6'b000010, 2'b00, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0));
    // beq taken then not taken (run dropped on the second)
    addVec(1, 1, 0, 0, I_BEQ, o_fetch_rdy);
    addVec(1, 0, 0, 1, I_BEQ, o_dec);
    addVec(1, 0, 0, 1, I_BEQ, mk(3'd3, 6'b000001, 2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0));
    addVec(1, 1, 0, 0, I_BEQ, o_fetch_rdy);
    addVec(1, 0, 0, 0, I_BEQ, o_dec);
    addVec(0, 0, 0, 0, I_BEQ, mk(3'd3, 6'b000000, 2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0));
    addVec(0, 0, 0, 0, I_BEQ, o_idle);
    // sw with one fetch stall, then jal
    addVec(1, 0, 0, 0, I_SW, o_idle);
    addVec(1, 0, 0, 0, I_SW, o_fetch);
    addVec(1, 1, 0, 0, I_SW, o_fetch_rdy);
    addVec(1, 0, 0, 0, I_SW, o_dec);
    addVec(1, 0, 0, 0, I_SW, mk(3'd3, 6'b000000, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0));
    addVec(1, 0, 1, 0, I_SW, mk(3'd4, 6'b001000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0));
    addVec(1, 1, 0, 0, I_JAL, o_fetch_rdy);
    addVec(1, 0, 0, 0, I_JAL, o_dec);
    addVec(1, 0, 0, 0, I_JAL, mk(3'd3, 6'b000001, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0));
    addVec(0, 0, 0, 0, I_JAL, mk(3'd5, 6'b000010, 2'b00, 2'b00, 1'b0, 2'b00, 2'b10, 1'b0));
    // illegal opcode traps after decode and stays there
    addVec(1, 0, 0, 0, I_ILL, o_idle);
    addVec(1, 1, 0, 0, I_ILL, o_fetch_rdy);
    addVec(1, 0, 0, 0, I_ILL, o_dec);
    addVec(0, 0, 0, 0, I_ILL, o_trap);
    addVec(1, 1, 1, 1, I_ILL, o_trap);

    #3;
    checkOutput("reset_state", o_idle);
    #9;
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    resetPulse("trap_cleared_by_reset");

    stepCheck("mid_idle", 1, 0, 0, 0, I_ADDI, o_idle);
    stepCheck("mid_fetch", 1, 0, 0, 0, I_ADDI, o_fetch);
    resetPulse("reset_drops_imem_req");

    stepCheck("to_idle", 1, 0, 0, 0, I_ADDI, o_idle);
    for (int i = 0; i < 4; i++)
      stepCheck($sformatf("to_stall%0d", i), 1, 0, 0, 0, I_ADDI, o_fetch);
    stepCheck("to_trap", 1, 0, 0, 0, I_ADDI, o_trap);
    resetPulse("to_reset");

    stepCheck("rw_idle", 1, 0, 0, 0, I_ADDI, o_idle);
    for (int i = 0; i < 3; i++)
      stepCheck($sformatf("rw_stall%0d", i), 1, 0, 0, 0, I_ADDI, o_fetch);
    stepCheck("rw_ready_last", 1, 1, 0, 0, I_ADDI, o_fetch_rdy);
    stepCheck("rw_dec_no_trap", 1, 0, 0, 0, I_ADDI, o_dec);
    resetPulse("rw_reset");

    stepCheck("dto_idle", 1, 0, 0, 0, I_SW, o_idle);
    stepCheck("dto_fetch", 1, 1, 0, 0, I_SW, o_fetch_rdy);
    stepCheck("dto_dec", 1, 0, 0, 0, I_SW, o_dec);
    stepCheck("dto_exe", 1, 0, 0, 0, I_SW,
              mk(3'd3, 6'b000000, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0));
    for (int i = 0; i < 4; i++)
      stepCheck($sformatf("dto_stall%0d", i), 1, 0, 0, 0, I_SW,
                mk(3'd4, 6'b001000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0));
    stepCheck("dto_trap", 1, 0, 1, 0, I_SW, o_trap);

    $display("%0d/%0d checks passed", num_pass, num_checks);
    $finish;
  end

endmodule
